// File: rtl/alu_32bit.sv
// Registered 32-bit ALU: 16 unsigned operations, result and carry/borrow registered with one-cycle latency.
// Optional combinational divider for opcode 0011 is enabled by defining ALU_32BIT_DIV_EN.
module alu_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALU_Sel,
  output logic [31:0] ALU_Out,
  output logic        Carryout
);

  localparam int DATA_W = 32;

  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [DATA_W-1:0] res_c;
  logic              carry_c;
  logic [DATA_W-1:0] alu_out_p1;
  logic              carry_p1;

  assign sum_c  = {1'b0, A} + {1'b0, B};
  // Bit 32 of the zero-extended difference is set exactly when A < B.
  assign diff_c = {1'b0, A} - {1'b0, B};

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (ALU_Sel)
      4'b0000: begin
        res_c   = sum_c[DATA_W-1:0];
        carry_c = sum_c[DATA_W];
      end
      4'b0001: begin
        res_c   = diff_c[DATA_W-1:0];
        carry_c = diff_c[DATA_W];
      end
      4'b0010: res_c = A * B;
      4'b0011: begin
`ifdef ALU_32BIT_DIV_EN
        res_c = (B == '0) ? '1 : A / B;
`else
        res_c = '0;
`endif
      end
      4'b0100: res_c = {A[DATA_W-2:0], 1'b0};
      4'b0101: res_c = {1'b0, A[DATA_W-1:1]};
      4'b0110: res_c = {A[DATA_W-2:0], A[DATA_W-1]};
      4'b0111: res_c = {A[0], A[DATA_W-1:1]};
      4'b1000: res_c = A & B;
      4'b1001: res_c = A | B;
      4'b1010: res_c = A ^ B;
      4'b1011: res_c = ~(A | B);
      4'b1100: res_c = ~(A & B);
      4'b1101: res_c = ~(A ^ B);
      4'b1110: res_c = {{(DATA_W-1){1'b0}}, (A > B)};
      4'b1111: res_c = {{(DATA_W-1){1'b0}}, (A == B)};
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_p1 <= '0;
      carry_p1   <= 1'b0;
    end else begin
      alu_out_p1 <= res_c;
      carry_p1   <= carry_c;
    end
  end

  assign ALU_Out  = alu_out_p1;
  assign Carryout = carry_p1;

endmodule

// File: tb/tb_alu_32bit.sv
// Directed self-checking bench for alu_32bit; expectations for opcode 0011 follow ALU_32BIT_DIV_EN.
module tb_alu_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        carryout;

  int n_checks = 0;
  int n_errors = 0;

  alu_32bit dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .ALU_Sel  (alu_sel),
    .ALU_Out  (alu_out),
    .Carryout (carryout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Present an operation, clock it in, and sample just after the edge.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] op_a, input logic [31:0] op_b);
    alu_sel = sel;
    a       = op_a;
    b       = op_b;
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input string tag, input logic [3:0] sel, input logic [31:0] op_a,
                          input logic [31:0] op_b, input logic [31:0] exp_out, input logic exp_c);
    run_op(sel, op_a, op_b);
    check({tag, ".out"}, alu_out, exp_out);
    check({tag, ".c"}, {31'b0, carryout}, {31'b0, exp_c});
  endtask

  localparam logic [31:0] X = 32'h12345678;
  localparam logic [31:0] Y = 32'h87654321;

  logic [31:0] exp_div;
  logic [31:0] exp_div0;

  initial begin
`ifdef ALU_32BIT_DIV_EN
    exp_div  = 32'h6;
    exp_div0 = 32'hFFFFFFFF;
`else
    exp_div  = 32'h0;
    exp_div0 = 32'h0;
`endif
    // Reset held two cycles with an ADD presented
    rst = 1'b1;
    run_op(4'b0000, 32'd5, 32'd7);
    check("rst1.out", alu_out, 32'd0);
    check("rst1.c", {31'b0, carryout}, 32'd0);
    run_op(4'b0000, 32'd5, 32'd7);
    check("rst2.out", alu_out, 32'd0);
    rst = 1'b0;
    op_check("post_rst_add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);

    op_check("add", 4'b0000, X, Y, 32'h99999999, 1'b0);
    op_check("sub", 4'b0001, X, Y, 32'h8ACF1357, 1'b1);
    op_check("sub_nb", 4'b0001, Y, X, 32'h7530ECA9, 1'b0);
    op_check("add_ovf", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1);

    op_check("mul", 4'b0010, 32'h12, 32'h34, 32'h3A8, 1'b0);
    op_check("div", 4'b0011, 32'h78, 32'h12, exp_div, 1'b0);
    op_check("div0", 4'b0011, 32'h78, 32'h0, exp_div0, 1'b0);

    op_check("shl", 4'b0100, X, Y, 32'h2468ACF0, 1'b0);
    op_check("shr", 4'b0101, X, Y, 32'h091A2B3C, 1'b0);
    op_check("rol", 4'b0110, X, Y, 32'h2468ACF0, 1'b0);
    op_check("ror", 4'b0111, X, Y, 32'h091A2B3C, 1'b0);
    op_check("rol_wrap", 4'b0110, 32'h80000001, Y, 32'h00000003, 1'b0);
    op_check("ror_wrap", 4'b0111, 32'h80000001, Y, 32'hC0000000, 1'b0);
    op_check("shl_msb", 4'b0100, 32'h80000001, Y, 32'h00000002, 1'b0);
    op_check("shr_msb", 4'b0101, 32'h80000001, Y, 32'h40000000, 1'b0);

    op_check("and", 4'b1000, X, Y, 32'h02244220, 1'b0);
    op_check("or", 4'b1001, X, Y, 32'h97755779, 1'b0);
    op_check("xor", 4'b1010, X, Y, 32'h95511559, 1'b0);
    op_check("nor", 4'b1011, X, Y, 32'h688AA886, 1'b0);
    op_check("nand", 4'b1100, X, Y, 32'hFDDBBDDF, 1'b0);
    op_check("xnor", 4'b1101, X, Y, 32'h6AAEEAA6, 1'b0);

    op_check("gt_lo", 4'b1110, X, Y, 32'd0, 1'b0);
    op_check("gt_hi", 4'b1110, Y, X, 32'd1, 1'b0);
    op_check("eq_same", 4'b1111, X, X, 32'd1, 1'b0);
    op_check("gt_same", 4'b1110, X, X, 32'd0, 1'b0);
    op_check("eq_diff", 4'b1111, X, Y, 32'd0, 1'b0);

    // Outputs must hold between edges even as inputs change
    run_op(4'b0000, 32'hFFFFFFFF, 32'd1);
    alu_sel = 4'b1001;
    a       = X;
    b       = Y;
    #2;
    check("hold.out", alu_out, 32'h0);
    check("hold.c", {31'b0, carryout}, 32'd1);

    // Back-to-back opcodes, each visible exactly one edge later
    op_check("b2b_sub", 4'b0001, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b1);
    op_check("b2b_mul", 4'b0010, 32'h10000, 32'h10001, 32'h00010000, 1'b0);
    op_check("b2b_xor", 4'b1010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0);
    op_check("b2b_add", 4'b0000, 32'h80000000, 32'h80000000, 32'h0, 1'b1);
    op_check("b2b_eq", 4'b1111, 32'd0, 32'd0, 32'd1, 1'b0);

    // Reset mid-stream discards the operation sampled on that edge
    rst = 1'b1;
    run_op(4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mid_rst.out", alu_out, 32'd0);
    check("mid_rst.c", {31'b0, carryout}, 32'd0);
    rst = 1'b0;
    op_check("after_rst", 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
